// File: rtl/ysyx_22040237_wb_sched_pkg.sv
// Shared constants for the GPR write-back scheduler and its arbiter.
package ysyx_22040237_wb_sched_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned REG_NUM   = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam logic [63:0] REG_RESET = 64'h0;

endpackage

// File: rtl/ysyx_22040237_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first valid requester at or after the pointer.
module ysyx_22040237_rr_arb #(
  parameter int unsigned NREQ = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] valid_i,
  output logic [NREQ-1:0] gnt_o
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             found;
  int unsigned      j;

  // Search upward from the pointer, wrapping modulo NREQ; pointer moves past the winner.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = (32'(ptr_q) + k) % NREQ;
      if (!found && valid_i[PTR_W'(j)]) begin
        found               = 1'b1;
        gnt_o[PTR_W'(j)]    = 1'b1;
        ptr_d               = PTR_W'((j + 1) % NREQ);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ysyx_22040237_wb_sched.sv
// GPR write-port scheduler: round-robin write-back arbitration, registered regfile write,
// and a per-register pending-write scoreboard for hazard detection.
module ysyx_22040237_wb_sched
  import ysyx_22040237_wb_sched_pkg::REG_IDX_W;
  import ysyx_22040237_wb_sched_pkg::REG_RESET;
#(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned XLEN    = ysyx_22040237_wb_sched_pkg::XLEN,
  parameter int unsigned REG_NUM = ysyx_22040237_wb_sched_pkg::REG_NUM,
  parameter int unsigned CNT_W   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid_i,
  output logic [NREQ-1:0]           req_ready_o,
  input  logic [NREQ*REG_IDX_W-1:0] req_idx_i,
  input  logic [NREQ*XLEN-1:0]      req_data_i,
  input  logic                      alloc_en_i,
  input  logic [REG_IDX_W-1:0]      alloc_idx_i,
  output logic                      alloc_ready_o,
  output logic [REG_NUM-1:0]        busy_o,
  output logic                      rd_wr_en_o,
  output logic [REG_IDX_W-1:0]      rd_wr_idx_o,
  output logic [XLEN-1:0]           rd_wr_data_o,
  output logic                      sb_err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NREQ-1:0]      gnt;
  logic [REG_IDX_W-1:0] sel_idx;
  logic [XLEN-1:0]      sel_data;

  logic                 rd_wr_en_q,   rd_wr_en_d;
  logic [REG_IDX_W-1:0] rd_wr_idx_q,  rd_wr_idx_d;
  logic [XLEN-1:0]      rd_wr_data_q, rd_wr_data_d;

  logic [CNT_W-1:0]     cnt_q [REG_NUM];
  logic [CNT_W-1:0]     cnt_d [REG_NUM];
  logic [REG_NUM-1:0]   busy_q, busy_d;
  logic                 sb_err_q, sb_err_d;
  logic                 alloc_fire;
  logic                 inc, dec;

  ysyx_22040237_rr_arb #(
    .NREQ (NREQ)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid_i (req_valid_i),
    .gnt_o   (gnt)
  );

  assign req_ready_o   = gnt;
  assign alloc_ready_o = (alloc_idx_i == '0) || (cnt_q[alloc_idx_i] != CNT_MAX);
  assign alloc_fire    = alloc_en_i && alloc_ready_o && (alloc_idx_i != '0);

  // Winner mux and next write; x0 writes are consumed but never reach the regfile.
  always_comb begin
    sel_idx      = '0;
    sel_data     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_idx  = req_idx_i[REG_IDX_W*i +: REG_IDX_W];
        sel_data = req_data_i[XLEN*i +: XLEN];
      end
    end
    rd_wr_en_d   = (|gnt) && (sel_idx != '0);
    rd_wr_idx_d  = rd_wr_idx_q;
    rd_wr_data_d = rd_wr_data_q;
    if (rd_wr_en_d) begin
      rd_wr_idx_d  = sel_idx;
      rd_wr_data_d = sel_data;
    end
  end

  // Pending counters: alloc increments, the registered write being captured decrements.
  always_comb begin
    sb_err_d = sb_err_q;
    inc      = 1'b0;
    dec      = 1'b0;
    for (int unsigned r = 0; r < REG_NUM; r++) begin
      inc      = alloc_fire && (alloc_idx_i == REG_IDX_W'(r));
      dec      = rd_wr_en_q && (rd_wr_idx_q == REG_IDX_W'(r));
      cnt_d[r] = cnt_q[r];
      if (inc && !dec) begin
        cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (dec && !inc) begin
        if (cnt_q[r] == '0) begin
          sb_err_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] - CNT_W'(1);
        end
      end
      busy_d[r] = (r != 0) && (cnt_d[r] != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_wr_en_q   <= 1'b0;
      rd_wr_idx_q  <= '0;
      rd_wr_data_q <= XLEN'(REG_RESET);
      busy_q       <= '0;
      sb_err_q     <= 1'b0;
      for (int unsigned r = 0; r < REG_NUM; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      rd_wr_en_q   <= rd_wr_en_d;
      rd_wr_idx_q  <= rd_wr_idx_d;
      rd_wr_data_q <= rd_wr_data_d;
      busy_q       <= busy_d;
      sb_err_q     <= sb_err_d;
      for (int unsigned r = 0; r < REG_NUM; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  assign rd_wr_en_o   = rd_wr_en_q;
  assign rd_wr_idx_o  = rd_wr_idx_q;
  assign rd_wr_data_o = rd_wr_data_q;
  assign busy_o       = busy_q;
  assign sb_err_o     = sb_err_q;

endmodule

// File: tb/tb_ysyx_22040237_wb_sched.sv
// Scoreboard bench for the write-back scheduler: per-cycle reference model of arbitration,
// output register and pending counters, plus scenario-specific inline checks.
module tb_ysyx_22040237_wb_sched;

  localparam int unsigned NREQ = 3;
  localparam int unsigned XLEN = 64;
  localparam int unsigned IW   = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid_i;
  logic [NREQ-1:0]      req_ready_o;
  logic [NREQ*IW-1:0]   req_idx_i;
  logic [NREQ*XLEN-1:0] req_data_i;
  logic                 alloc_en_i;
  logic [IW-1:0]        alloc_idx_i;
  logic                 alloc_ready_o;
  logic [31:0]          busy_o;
  logic                 rd_wr_en_o;
  logic [IW-1:0]        rd_wr_idx_o;
  logic [XLEN-1:0]      rd_wr_data_o;
  logic                 sb_err_o;

  ysyx_22040237_wb_sched dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_idx_i     (req_idx_i),
    .req_data_i    (req_data_i),
    .alloc_en_i    (alloc_en_i),
    .alloc_idx_i   (alloc_idx_i),
    .alloc_ready_o (alloc_ready_o),
    .busy_o        (busy_o),
    .rd_wr_en_o    (rd_wr_en_o),
    .rd_wr_idx_o   (rd_wr_idx_o),
    .rd_wr_data_o  (rd_wr_data_o),
    .sb_err_o      (sb_err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            en;
    logic [IW-1:0]   idx;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  int            errors = 0;
  int            checks = 0;
  int unsigned   m_ptr;
  int unsigned   m_cnt [32];
  logic          m_err;
  logic          m_out_en;
  logic [IW-1:0] m_out_idx;

  task automatic model_reset();
    m_ptr     = 0;
    m_err     = 1'b0;
    m_out_en  = 1'b0;
    m_out_idx = '0;
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    exp_q.delete();
  endtask

  task automatic clear_inputs();
    req_valid_i = '0;
    req_idx_i   = '0;
    req_data_i  = '0;
    alloc_en_i  = 1'b0;
    alloc_idx_i = '0;
  endtask

  task automatic set_req(input int unsigned i, input logic v, input logic [IW-1:0] idx,
                         input logic [XLEN-1:0] data);
    req_valid_i[i]           = v;
    req_idx_i[IW*i +: IW]    = idx;
    req_data_i[XLEN*i +: XLEN] = data;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: predict grant/alloc, push the expected write, then pop and compare after the edge.
  task automatic step();
    logic [NREQ-1:0] exp_gnt;
    logic [31:0]     exp_busy;
    wr_t             w;
    wr_t             e;
    logic            a_rdy;
    logic            inc;
    logic [IW-1:0]   a_idx;
    int unsigned     win;
    int unsigned     j;
    #1;
    exp_gnt = '0;
    win     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = (m_ptr + k) % NREQ;
      if (exp_gnt == '0 && req_valid_i[j]) begin
        exp_gnt[j] = 1'b1;
        win        = j;
      end
    end
    checks++;
    if (req_ready_o !== exp_gnt) begin
      errors++;
      $display("FAIL grant: req_ready_o=%b expected=%b", req_ready_o, exp_gnt);
    end
    w = '0;
    if (exp_gnt != '0) begin
      w.idx  = req_idx_i[IW*win +: IW];
      w.data = req_data_i[XLEN*win +: XLEN];
      w.en   = (w.idx != '0);
      m_ptr  = (win + 1) % NREQ;
    end
    exp_q.push_back(w);
    a_idx = alloc_idx_i;
    a_rdy = (a_idx == '0) || (m_cnt[a_idx] != 3);
    checks++;
    if (alloc_ready_o !== a_rdy) begin
      errors++;
      $display("FAIL alloc_ready: got=%b expected=%b idx=%0d", alloc_ready_o, a_rdy, a_idx);
    end
    inc = alloc_en_i && a_rdy && (a_idx != '0);
    @(posedge clk);
    #1;
    if (!(inc && m_out_en && a_idx == m_out_idx)) begin
      if (inc) m_cnt[a_idx] = m_cnt[a_idx] + 1;
      if (m_out_en) begin
        if (m_cnt[m_out_idx] == 0) m_err = 1'b1;
        else m_cnt[m_out_idx] = m_cnt[m_out_idx] - 1;
      end
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected write queued");
    end else begin
      e = exp_q.pop_front();
      if (rd_wr_en_o !== e.en) begin
        errors++;
        $display("FAIL wr_en: got=%b expected=%b", rd_wr_en_o, e.en);
      end else if (e.en && (rd_wr_idx_o !== e.idx || rd_wr_data_o !== e.data)) begin
        errors++;
        $display("FAIL wr_payload: got idx=%0d data=%h expected idx=%0d data=%h",
                 rd_wr_idx_o, rd_wr_data_o, e.idx, e.data);
      end
      m_out_en  = e.en;
      m_out_idx = e.idx;
    end
    exp_busy = '0;
    for (int r = 1; r < 32; r++) exp_busy[r] = (m_cnt[r] != 0);
    checks++;
    if (busy_o !== exp_busy) begin
      errors++;
      $display("FAIL busy: got=%h expected=%h", busy_o, exp_busy);
    end
    checks++;
    if (sb_err_o !== m_err) begin
      errors++;
      $display("FAIL sb_err: got=%b expected=%b", sb_err_o, m_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    set_req(0, 1'b1, 5'd5, 64'h1234);
    alloc_en_i  = 1'b1;
    alloc_idx_i = 5'd3;
    #23;
    checks++;
    if (rd_wr_en_o !== 1'b0 || busy_o !== 32'h0 || sb_err_o !== 1'b0 ||
        rd_wr_idx_o !== 5'd0 || rd_wr_data_o !== 64'h0) begin
      errors++;
      $display("FAIL reset_hold: en=%b busy=%h err=%b idx=%0d data=%h expected all zero",
               rd_wr_en_o, busy_o, sb_err_o, rd_wr_idx_o, rd_wr_data_o);
    end
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    model_reset();
    step();
  endtask

  task automatic test_single();
    set_req(0, 1'b1, 5'd5, 64'hDEAD_BEEF);
    #1;
    checks++;
    if (req_ready_o !== 3'b001) begin
      errors++;
      $display("FAIL single_grant: got=%b expected=001", req_ready_o);
    end
    step();
    checks++;
    if (rd_wr_en_o !== 1'b1 || rd_wr_idx_o !== 5'd5 || rd_wr_data_o !== 64'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_write: en=%b idx=%0d data=%h expected 1/5/deadbeef",
               rd_wr_en_o, rd_wr_idx_o, rd_wr_data_o);
    end
    clear_inputs();
    step();
    checks++;
    if (rd_wr_en_o !== 1'b0) begin
      errors++;
      $display("FAIL single_one_cycle: en=%b expected=0", rd_wr_en_o);
    end
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] want;
    apply_reset();
    for (int unsigned i = 0; i < NREQ; i++)
      set_req(i, 1'b1, 5'(10 + i), 64'hA000 + 64'(i));
    for (int n = 0; n < 6; n++) begin
      want = 3'b001 << (n % 3);
      #1;
      checks++;
      if (req_ready_o !== want) begin
        errors++;
        $display("FAIL fair_grant%0d: got=%b expected=%b", n, req_ready_o, want);
      end
      step();
      checks++;
      if (rd_wr_en_o !== 1'b1 || rd_wr_idx_o !== 5'(10 + (n % 3))) begin
        errors++;
        $display("FAIL fair_write%0d: en=%b idx=%0d expected 1/%0d", n, rd_wr_en_o,
                 rd_wr_idx_o, 10 + (n % 3));
      end
    end
    clear_inputs();
    step();
  endtask

  task automatic test_x0();
    logic [31:0] busy_before;
    apply_reset();
    alloc_en_i  = 1'b1;
    alloc_idx_i = 5'd4;
    step();
    clear_inputs();
    busy_before = busy_o;
    set_req(1, 1'b1, 5'd0, 64'h1);
    #1;
    checks++;
    if (req_ready_o !== 3'b010) begin
      errors++;
      $display("FAIL x0_grant: got=%b expected=010", req_ready_o);
    end
    step();
    checks++;
    if (rd_wr_en_o !== 1'b0 || busy_o !== busy_before || busy_o !== 32'h10) begin
      errors++;
      $display("FAIL x0_effect: en=%b busy=%h expected en=0 busy=00000010", rd_wr_en_o, busy_o);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_scoreboard();
    apply_reset();
    alloc_en_i  = 1'b1;
    alloc_idx_i = 5'd7;
    step();
    step();
    alloc_en_i = 1'b0;
    checks++;
    if (busy_o[7] !== 1'b1) begin
      errors++;
      $display("FAIL sb_busy_set: busy[7]=%b expected=1", busy_o[7]);
    end
    set_req(2, 1'b1, 5'd7, 64'h77);
    step();
    step();
    clear_inputs();
    checks++;
    if (busy_o[7] !== 1'b1) begin
      errors++;
      $display("FAIL sb_busy_after_first: busy[7]=%b expected=1", busy_o[7]);
    end
    step();
    checks++;
    if (busy_o[7] !== 1'b0) begin
      errors++;
      $display("FAIL sb_busy_clear: busy[7]=%b expected=0", busy_o[7]);
    end
    alloc_en_i  = 1'b1;
    alloc_idx_i = 5'd7;
    step();
    step();
    step();
    #1;
    checks++;
    if (alloc_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL sb_saturate: alloc_ready=%b expected=0", alloc_ready_o);
    end
    step();
    alloc_en_i = 1'b0;
    set_req(2, 1'b1, 5'd7, 64'h78);
    step();
    clear_inputs();
    step();
    set_req(2, 1'b1, 5'd7, 64'h79);
    step();
    clear_inputs();
    alloc_en_i  = 1'b1;
    alloc_idx_i = 5'd7;
    step();
    alloc_en_i = 1'b0;
    #1;
    checks++;
    if (alloc_ready_o !== 1'b1 || busy_o[7] !== 1'b1) begin
      errors++;
      $display("FAIL sb_same_edge: alloc_ready=%b busy[7]=%b expected 1/1", alloc_ready_o, busy_o[7]);
    end
    alloc_en_i = 1'b1;
    step();
    alloc_en_i = 1'b0;
    #1;
    checks++;
    if (alloc_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL sb_same_edge_count: alloc_ready=%b expected=0 (count should reach 3)",
               alloc_ready_o);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_error();
    apply_reset();
    set_req(0, 1'b1, 5'd9, 64'h99);
    step();
    clear_inputs();
    step();
    checks++;
    if (sb_err_o !== 1'b1 || busy_o[9] !== 1'b0) begin
      errors++;
      $display("FAIL err_set: sb_err=%b busy[9]=%b expected 1/0", sb_err_o, busy_o[9]);
    end
    for (int n = 0; n < 3; n++) step();
    checks++;
    if (sb_err_o !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: sb_err=%b expected=1", sb_err_o);
    end
  endtask

  task automatic test_back_to_back_reset();
    alloc_en_i  = 1'b1;
    alloc_idx_i = 5'd6;
    set_req(0, 1'b1, 5'd6, 64'h66);
    set_req(1, 1'b1, 5'd8, 64'h88);
    step();
    step();
    clear_inputs();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (rd_wr_en_o !== 1'b0 || busy_o !== 32'h0 || sb_err_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: en=%b busy=%h err=%b expected 0/0/0",
               rd_wr_en_o, busy_o, sb_err_o);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_x0();
    test_scoreboard();
    test_error();
    test_back_to_back_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
